dcmac_rx_merge: RTL and testbench



---
 rtl/dcmac_rx_merge.sv | 218 +++++++++++++++++++++
 tb/tb_dcmac_rx_merge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmac_rx_merge.sv
// dcmac_rx_merge: rotating 4-segment DCMAC RX reassembly into one 128-bit packet stream.
// Define DCMAC_RX_MERGE_STATS_EN to build the pkt/err/drop counters; otherwise they read 0.
module dcmac_rx_merge (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] s0_tdata,
   input  logic [15:0]  s0_tkeep,
   input  logic [1:0]   s0_tuser,
   input  logic         s0_tlast,
   input  logic         s0_tvalid,
   output logic         s0_tready,
   input  logic [127:0] s1_tdata,
   input  logic [15:0]  s1_tkeep,
   input  logic [1:0]   s1_tuser,
   input  logic         s1_tlast,
   input  logic         s1_tvalid,
   output logic         s1_tready,
   input  logic [127:0] s2_tdata,
   input  logic [15:0]  s2_tkeep,
   input  logic [1:0]   s2_tuser,
   input  logic         s2_tlast,
   input  logic         s2_tvalid,
   output logic         s2_tready,
   input  logic [127:0] s3_tdata,
   input  logic [15:0]  s3_tkeep,
   input  logic [1:0]   s3_tuser,
   input  logic         s3_tlast,
   input  logic         s3_tvalid,
   output logic         s3_tready,
   output logic [127:0] m_axis_tdata,
   output logic [15:0]  m_axis_tkeep,
   output logic         m_axis_tuser,
   output logic         m_axis_tlast,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [31:0]  pkt_count,
   output logic [31:0]  err_count,
   output logic [31:0]  drop_count
);

   typedef enum logic {IDLE, PKT} state_t;

   state_t       state_q, state_d;
   logic [1:0]   ptr_q, ptr_d;
   logic         acc_q, acc_d;
   logic         h_vld_q, h_vld_d;
   logic         h_last_q, h_last_d;
   logic         h_user_q, h_user_d;
   logic [127:0] h_data_q, h_data_d;
   logic [15:0]  h_keep_q, h_keep_d;
   logic         m_vld_q, m_vld_d;
   logic         m_last_q, m_last_d;
   logic         m_user_q, m_user_d;
   logic [127:0] m_data_q, m_data_d;
   logic [15:0]  m_keep_q, m_keep_d;

   logic [127:0] cur_data;
   logic [15:0]  cur_keep;
   logic [1:0]   cur_user;
   logic         cur_last, cur_vld;
   logic         sop, err, e_new;
   logic         m_free, drop, h2m, rdy, pop, take, trunc;

   always_comb begin
      cur_data = s0_tdata;
      cur_keep = s0_tkeep;
      cur_user = s0_tuser;
      cur_last = s0_tlast;
      cur_vld  = s0_tvalid;
      unique case (ptr_q)
         2'd0: ;
         2'd1: begin
            cur_data = s1_tdata;
            cur_keep = s1_tkeep;
            cur_user = s1_tuser;
            cur_last = s1_tlast;
            cur_vld  = s1_tvalid;
         end
         2'd2: begin
            cur_data = s2_tdata;
            cur_keep = s2_tkeep;
            cur_user = s2_tuser;
            cur_last = s2_tlast;
            cur_vld  = s2_tvalid;
         end
         2'd3: begin
            cur_data = s3_tdata;
            cur_keep = s3_tkeep;
            cur_user = s3_tuser;
            cur_last = s3_tlast;
            cur_vld  = s3_tvalid;
         end
      endcase
   end

   // H advances only when it is closed by tlast or a successor beat is arriving
   always_comb begin
      sop    = cur_user[1];
      err    = cur_user[0];
      m_free = !m_vld_q || m_axis_tready;
      drop   = (state_q == IDLE) && !sop;
      h2m    = !reset && h_vld_q && m_free &&
               (h_last_q || (cur_vld && !drop));
      rdy    = !reset && (drop || !h_vld_q || h2m);
      pop    = cur_vld && rdy;
      take   = pop && !drop;
      trunc  = take && (state_q == PKT) && sop;
      e_new  = sop ? err : (acc_q | err);
   end

   assign s0_tready = rdy && (ptr_q == 2'd0);
   assign s1_tready = rdy && (ptr_q == 2'd1);
   assign s2_tready = rdy && (ptr_q == 2'd2);
   assign s3_tready = rdy && (ptr_q == 2'd3);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      acc_d    = acc_q;
      h_vld_d  = h_vld_q;
      h_last_d = h_last_q;
      h_user_d = h_user_q;
      h_data_d = h_data_q;
      h_keep_d = h_keep_q;
      m_vld_d  = m_vld_q;
      m_last_d = m_last_q;
      m_user_d = m_user_q;
      m_data_d = m_data_q;
      m_keep_d = m_keep_q;
      if (pop) ptr_d = ptr_q + 2'd1;
      if (h2m) begin
         m_vld_d  = 1'b1;
         m_data_d = h_data_q;
         m_keep_d = h_keep_q;
         m_last_d = h_last_q | trunc;
         m_user_d = h_user_q | trunc;
      end else if (m_vld_q && m_axis_tready) begin
         m_vld_d = 1'b0;
      end
      if (take) begin
         h_vld_d  = 1'b1;
         h_data_d = cur_data;
         h_keep_d = cur_keep;
         h_last_d = cur_last;
         h_user_d = cur_last & e_new;
         acc_d    = e_new;
         state_d  = cur_last ? IDLE : PKT;
      end else if (h2m) begin
         h_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         acc_q    <= 1'b0;
         h_vld_q  <= 1'b0;
         h_last_q <= 1'b0;
         h_user_q <= 1'b0;
         h_data_q <= '0;
         h_keep_q <= '0;
         m_vld_q  <= 1'b0;
         m_last_q <= 1'b0;
         m_user_q <= 1'b0;
         m_data_q <= '0;
         m_keep_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         acc_q    <= acc_d;
         h_vld_q  <= h_vld_d;
         h_last_q <= h_last_d;
         h_user_q <= h_user_d;
         h_data_q <= h_data_d;
         h_keep_q <= h_keep_d;
         m_vld_q  <= m_vld_d;
         m_last_q <= m_last_d;
         m_user_q <= m_user_d;
         m_data_q <= m_data_d;
         m_keep_q <= m_keep_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tvalid = m_vld_q;

`ifdef DCMAC_RX_MERGE_STATS_EN
   logic [31:0] pkt_q, err_q, drop_q;
   logic        eop_fire;

   assign eop_fire = m_vld_q && m_axis_tready && m_last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_q  <= '0;
         err_q  <= '0;
         drop_q <= '0;
      end else begin
         if (eop_fire && (pkt_q != '1)) pkt_q <= pkt_q + 32'd1;
         if (eop_fire && m_user_q && (err_q != '1)) err_q <= err_q + 32'd1;
         if (pop && drop && (drop_q != '1)) drop_q <= drop_q + 32'd1;
      end
   end

   assign pkt_count  = pkt_q;
   assign err_count  = err_q;
   assign drop_count = drop_q;
`else
   assign pkt_count  = 32'd0;
   assign err_count  = 32'd0;
   assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcmac_rx_merge.sv
// Randomized bench for dcmac_rx_merge against a packet-level reference model.
module tb_dcmac_rx_merge;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] sd [4];
   logic [15:0]  sk [4];
   logic [1:0]   su [4];
   logic [3:0]   sl, sv, sr;
   logic [127:0] m_axis_tdata;
   logic [15:0]  m_axis_tkeep;
   logic         m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [31:0]  pkt_count, err_count, drop_count;

   always #5 clk = ~clk;

   dcmac_rx_merge dut (
      .clk(clk), .reset(reset),
      .s0_tdata(sd[0]), .s0_tkeep(sk[0]), .s0_tuser(su[0]),
      .s0_tlast(sl[0]), .s0_tvalid(sv[0]), .s0_tready(sr[0]),
      .s1_tdata(sd[1]), .s1_tkeep(sk[1]), .s1_tuser(su[1]),
      .s1_tlast(sl[1]), .s1_tvalid(sv[1]), .s1_tready(sr[1]),
      .s2_tdata(sd[2]), .s2_tkeep(sk[2]), .s2_tuser(su[2]),
      .s2_tlast(sl[2]), .s2_tvalid(sv[2]), .s2_tready(sr[2]),
      .s3_tdata(sd[3]), .s3_tkeep(sk[3]), .s3_tuser(su[3]),
      .s3_tlast(sl[3]), .s3_tvalid(sv[3]), .s3_tready(sr[3]),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .pkt_count(pkt_count), .err_count(err_count),
      .drop_count(drop_count)
   );

   typedef struct {
      logic [127:0] d;
      logic [15:0]  k;
      logic         sop, err, last;
   } beat_t;

   typedef struct {
      logic [127:0] d;
      logic [15:0]  k;
      logic         last, user;
   } exp_t;

   beat_t src [$];
   exp_t  expq [$];
   int    hd, tag, cyc, first_pop, last_out;
   int    e_pkt, e_err, e_drop;
   bit    in_pkt, acc, prev_hold;
   logic [146:0] prev_val;
   int    n_vec, n_bad;

   task automatic chk(input string tag_s, input logic [159:0] got,
                      input logic [159:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag_s, got, exp);
      end
   endtask

   function automatic beat_t mk(input logic s, input logic e,
                                input logic l, input logic [15:0] k);
      beat_t b;
      tag++;
      b.d = {$urandom, $urandom, $urandom, 32'(tag)};
      b.k = k;
      b.sop = s;
      b.err = e;
      b.last = l;
      return b;
   endfunction

   function automatic void add(input beat_t b, input bit a);
      exp_t t;
      t.d = b.d;
      t.k = b.k;
      t.last = b.last;
      t.user = b.last & a;
      expq.push_back(t);
      if (b.last) begin
         e_pkt++;
         if (a) e_err++;
      end
      in_pkt = !b.last;
   endfunction

   // packet-level rules: beats outside a packet vanish, a sop mid-packet closes it as errored
   function automatic void push(input beat_t b);
      src.push_back(b);
      if (b.sop) begin
         if (in_pkt) begin
            exp_t t = expq.pop_back();
            t.last = 1'b1;
            t.user = 1'b1;
            expq.push_back(t);
            e_pkt++;
            e_err++;
         end
         acc = b.err;
         add(b, acc);
      end else if (in_pkt) begin
         acc = acc | b.err;
         add(b, acc);
      end else begin
         e_drop++;
      end
   endfunction

   task automatic check_counts();
`ifdef DCMAC_RX_MERGE_STATS_EN
      chk("pkt_count", 160'(pkt_count), 160'(e_pkt));
      chk("err_count", 160'(err_count), 160'(e_err));
      chk("drop_count", 160'(drop_count), 160'(e_drop));
`else
      chk("pkt_count", 160'(pkt_count), 160'(0));
      chk("err_count", 160'(err_count), 160'(0));
      chk("drop_count", 160'(drop_count), 160'(0));
`endif
   endtask

   task automatic cycle(input int mode);
      logic [146:0] cur;
      exp_t e;
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
         int p = (n - hd) & 3;
         bit g = (mode != 2) || ($urandom % 4 != 0);
         if (p < src.size() && g) begin
            sv[n] = 1'b1;
            sd[n] = src[p].d;
            sk[n] = src[p].k;
            su[n] = {src[p].sop, src[p].err};
            sl[n] = src[p].last;
         end else begin
            sv[n] = 1'b0;
            sd[n] = '0;
            sk[n] = '0;
            su[n] = '0;
            sl[n] = 1'b0;
         end
      end
      case (mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = cyc[0];
         default: m_axis_tready = ($urandom % 3 != 0);
      endcase
      #2;
      chk("rdy_onehot", 160'($countones(sr) <= 1), 160'(1));
      cur = {m_axis_tvalid, m_axis_tlast, m_axis_tuser,
             m_axis_tkeep, m_axis_tdata};
      if (prev_hold) chk("stall_hold", 160'(cur), 160'(prev_val));
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_val = cur;
      if (m_axis_tvalid && m_axis_tready) begin
         last_out = cyc;
         if (expq.size() == 0) begin
            chk("extra_beat", 160'(m_axis_tdata), 160'(0));
         end else begin
            e = expq.pop_front();
            chk("tdata", 160'(m_axis_tdata), 160'(e.d));
            chk("tkeep", 160'(m_axis_tkeep), 160'(e.k));
            chk("tlast", 160'(m_axis_tlast), 160'(e.last));
            if (e.last) chk("tuser", 160'(m_axis_tuser), 160'(e.user));
         end
      end
      for (int n = 0; n < 4; n++) begin
         if (sv[n] && sr[n]) begin
            chk("pop_seg", 160'(n), 160'(hd & 3));
            if (first_pop < 0) first_pop = cyc;
            void'(src.pop_front());
            hd++;
         end
      end
      cyc++;
   endtask

   task automatic run(input int mode, input int budget, input bit drain);
      int c = 0;
      first_pop = -1;
      while (1) begin
         if (drain && src.size() == 0 && expq.size() == 0) break;
         if (c == budget) begin
            if (drain)
               chk("timeout", 160'(src.size() + expq.size()), 160'(0));
            break;
         end
         cycle(mode);
         c++;
      end
      repeat (3) cycle(mode);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sv = '0;
      m_axis_tready = 1'b1;
      src.delete();
      expq.delete();
      hd = 0;
      in_pkt = 0;
      acc = 0;
      e_pkt = 0;
      e_err = 0;
      e_drop = 0;
      prev_hold = 0;
      #2;
      chk("rst_tready", 160'(sr), 160'(0));
      @(negedge clk);
      chk("rst_mout", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                              m_axis_tkeep, m_axis_tdata}), 160'(0));
      chk("rst_cnt", 160'({pkt_count, err_count, drop_count}), 160'(0));
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      sv = '0;
      sl = '0;
      m_axis_tready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         sd[n] = '0;
         sk[n] = '0;
         su[n] = '0;
      end
      n_vec = 0;
      n_bad = 0;
      tag = 0;
      cyc = 0;
      repeat (2) @(negedge clk);
      do_reset();

      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(0, 0, 1, 16'h00FF));
      run(0, 50, 1);
      check_counts();

      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(0, 1, 1, 16'h000F));
      run(0, 50, 1);
      check_counts();

      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 1, 0, 16'hFFFF));
      push(mk(0, 0, 1, 16'h0FFF));
      run(0, 50, 1);
      check_counts();

      push(mk(1, 0, 1, 16'h0003));
      run(0, 50, 1);
      chk("latency", 160'(last_out - first_pop), 160'(2));

      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 0, 1, 16'h7FFF));
      run(0, 50, 1);
      check_counts();

      for (int i = 0; i < 16; i++) push(mk(1, 0, 1, 16'(i + 1)));
      run(0, 100, 1);
      chk("throughput", 160'(last_out - first_pop), 160'(17));

      for (int i = 0; i < 12; i++) push(mk(1, i[0], 1, 16'hFFFF));
      run(1, 100, 1);
      chk("tput_half", 160'((last_out - first_pop) <= 26), 160'(1));
      check_counts();

      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      push(mk(0, 0, 0, 16'hFFFF));
      run(0, 3, 0);
      do_reset();
      push(mk(1, 0, 0, 16'hFFFF));
      push(mk(0, 1, 1, 16'h1FFF));
      run(0, 50, 1);
      check_counts();

      for (int i = 0; i < 200; i++) begin
         int len = 1 + int'($urandom % 5);
         bit tr = (i != 199) && ($urandom % 6 == 0);
         if (!in_pkt && $urandom % 4 == 0)
            repeat ($urandom % 3) push(mk(0, $urandom % 2, $urandom % 2, 16'($urandom)));
         for (int j = 0; j < len; j++)
            push(mk(j == 0, $urandom % 8 == 0, (j == len - 1) && !tr,
                    16'($urandom)));
      end
      run(2, 20000, 1);
      check_counts();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
